// File: rtl/traffic_demand_arbiter_pkg.sv
// Shared types and defaults for the demand-actuated intersection scheduler.
package tlc_pkg;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  typedef enum logic [2:0] {
    RST_RED,
    MAIN_GREEN,
    MAIN_YELLOW,
    MAIN_RED,
    SRV_GREEN,
    SRV_YELLOW,
    SRV_RED
  } state_t;

  typedef enum logic [1:0] {
    PH_MAIN = 2'd0,
    PH_TURN = 2'd1,
    PH_SIDE = 2'd2,
    PH_PED  = 2'd3
  } phase_t;

  localparam int DEF_MIN_GREEN  = 7;
  localparam int DEF_YELLOW_T   = 3;
  localparam int DEF_ALL_RED_T  = 1;
  localparam int DEF_TURN_GREEN = 3;
  localparam int DEF_SIDE_GREEN = 4;
  localparam int DEF_PED_WALK   = 5;
  localparam int DEF_PED_CLEAR  = 3;

  function automatic int max_dur(input int a, input int b, input int c, input int d,
                                 input int e, input int f, input int g);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    if (f > m) m = f;
    if (g > m) m = g;
    return m;
  endfunction

endpackage

// File: rtl/traffic_demand_arbiter_if.sv
// Detector/light bundle between the scheduler (master) and the intersection (slave).
interface traffic_demand_arbiter_if;
  import tlc_pkg::*;

  logic       req_side;
  logic       req_turn;
  logic       req_ped;
  logic       preempt;
  logic [2:0] light_M1;
  logic [2:0] light_M2;
  logic [2:0] light_MT;
  logic [2:0] light_S;
  logic       walk;
  logic [1:0] grant;
  logic [2:0] pending;

  modport master (
    input  req_side, req_turn, req_ped, preempt,
    output light_M1, light_M2, light_MT, light_S, walk, grant, pending
  );

  modport slave (
    output req_side, req_turn, req_ped, preempt,
    input  light_M1, light_M2, light_MT, light_S, walk, grant, pending
  );

endinterface

// File: rtl/traffic_demand_arbiter_timer.sv
// Loadable phase down-counter; done flags the last cycle of the current duration.
module tlc_phase_timer #(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             done
);

  logic [WIDTH-1:0] count;

  // Saturates at zero so an indefinite state (main green) can keep waiting.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= INIT;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/traffic_demand_arbiter.sv
// Demand-actuated phase scheduler: main green by default, round-robin service of latched requests.
// Define TLC_PED_EN to enable the pedestrian phase (req_ped, walk, grant = PED).
module traffic_demand_arbiter
  import tlc_pkg::*;
#(
  parameter int MIN_GREEN  = DEF_MIN_GREEN,
  parameter int YELLOW_T   = DEF_YELLOW_T,
  parameter int ALL_RED_T  = DEF_ALL_RED_T,
  parameter int TURN_GREEN = DEF_TURN_GREEN,
  parameter int SIDE_GREEN = DEF_SIDE_GREEN,
  parameter int PED_WALK   = DEF_PED_WALK,
  parameter int PED_CLEAR  = DEF_PED_CLEAR
) (
  input  logic                     clk,
  input  logic                     rst,
  traffic_demand_arbiter_if.master bus
);

  localparam int TW = $clog2(max_dur(MIN_GREEN, YELLOW_T, ALL_RED_T, TURN_GREEN,
                                     SIDE_GREEN, PED_WALK, PED_CLEAR)) + 1;

  localparam logic [TW-1:0] T_MIN  = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] T_YEL  = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] T_ARED = TW'(ALL_RED_T - 1);
  localparam logic [TW-1:0] T_TURN = TW'(TURN_GREEN - 1);
  localparam logic [TW-1:0] T_SIDE = TW'(SIDE_GREEN - 1);
  localparam logic [TW-1:0] T_WALK = TW'(PED_WALK - 1);
  localparam logic [TW-1:0] T_PCLR = TW'(PED_CLEAR - 1);

`ifdef TLC_PED_EN
  localparam bit PED_EN = 1'b1;
`else
  localparam bit PED_EN = 1'b0;
`endif

  state_t     state, state_nx;
  phase_t     phase, phase_nx;
  phase_t     rr_ptr, rr_nx;
  phase_t     chosen;
  logic [2:0] pending, pending_nx;
  logic [2:0] req, ignore_mask, clear_mask;
  logic       abort, abort_nx;
  logic       enter_srv;
  logic       t_load, t_done;
  logic [TW-1:0] t_value;
  logic [2:0] m1_q, m2_q, mt_q, s_q;
  logic [2:0] m1_nx, m2_nx, mt_nx, s_nx, col;
  logic       walk_q, walk_nx;
  logic [1:0] grant_q, grant_nx;

  function automatic logic [2:0] phase_mask(input phase_t p);
    case (p)
      PH_TURN: return 3'b001;
      PH_SIDE: return 3'b010;
      PH_PED:  return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic phase_t next_phase(input phase_t p);
    case (p)
      PH_TURN: return PH_SIDE;
      PH_SIDE: return PED_EN ? PH_PED : PH_TURN;
      default: return PH_TURN;
    endcase
  endfunction

  // First pending phase at or after the pointer; PH_MAIN when nothing is eligible.
  function automatic phase_t pick(input phase_t ptr, input logic [2:0] pend);
    phase_t p, sel;
    sel = PH_MAIN;
    p   = ptr;
    for (int i = 0; i < 3; i++) begin
      if (sel == PH_MAIN && (pend & phase_mask(p)) != 3'b000) sel = p;
      p = next_phase(p);
    end
    return sel;
  endfunction

  function automatic logic [TW-1:0] green_time(input phase_t p);
    case (p)
      PH_TURN: return T_TURN;
      PH_SIDE: return T_SIDE;
      default: return T_WALK;
    endcase
  endfunction

`ifdef TLC_PED_EN
  assign req = {bus.req_ped, bus.req_side, bus.req_turn};
`else
  assign req = {1'b0, bus.req_side, bus.req_turn};
`endif

  tlc_phase_timer #(
    .WIDTH (TW),
    .INIT  (T_ARED)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (t_load),
    .value (t_value),
    .done  (t_done)
  );

  always_comb begin
    state_nx  = state;
    phase_nx  = phase;
    rr_nx     = rr_ptr;
    abort_nx  = abort;
    t_load    = 1'b0;
    t_value   = '0;
    enter_srv = 1'b0;
    chosen    = pick(rr_ptr, pending);

    unique case (state)
      RST_RED: begin
        if (t_done) begin
          state_nx = MAIN_GREEN;
          t_load   = 1'b1;
          t_value  = T_MIN;
        end
      end
      MAIN_GREEN: begin
        abort_nx = 1'b0;
        if (bus.preempt) begin
          t_load  = 1'b1;
          t_value = T_MIN;
        end else if (t_done && pending != 3'b000) begin
          state_nx = MAIN_YELLOW;
          t_load   = 1'b1;
          t_value  = T_YEL;
        end
      end
      MAIN_YELLOW: begin
        if (bus.preempt) abort_nx = 1'b1;
        if (t_done) begin
          state_nx = MAIN_RED;
          t_load   = 1'b1;
          t_value  = T_ARED;
        end
      end
      MAIN_RED: begin
        if (bus.preempt) abort_nx = 1'b1;
        if (t_done) begin
          // A preempt seen anywhere in the clearance cancels the service.
          if (abort || bus.preempt || chosen == PH_MAIN) begin
            state_nx = MAIN_GREEN;
            phase_nx = PH_MAIN;
            t_load   = 1'b1;
            t_value  = T_MIN;
          end else begin
            state_nx  = SRV_GREEN;
            phase_nx  = chosen;
            rr_nx     = next_phase(chosen);
            enter_srv = 1'b1;
            t_load    = 1'b1;
            t_value   = green_time(chosen);
          end
        end
      end
      SRV_GREEN: begin
        if (bus.preempt || t_done) begin
          state_nx = SRV_YELLOW;
          t_load   = 1'b1;
          t_value  = (phase == PH_PED) ? T_PCLR : T_YEL;
        end
      end
      SRV_YELLOW: begin
        if (t_done) begin
          state_nx = SRV_RED;
          t_load   = 1'b1;
          t_value  = T_ARED;
        end
      end
      SRV_RED: begin
        if (t_done) begin
          state_nx = MAIN_GREEN;
          phase_nx = PH_MAIN;
          t_load   = 1'b1;
          t_value  = T_MIN;
        end
      end
      default: state_nx = RST_RED;
    endcase

    ignore_mask = (state == SRV_GREEN) ? phase_mask(phase) : 3'b000;
    clear_mask  = enter_srv ? phase_mask(chosen) : 3'b000;
    pending_nx  = (pending | (req & ~ignore_mask)) & ~clear_mask;

    // Light decode from the next state so lights flip on the same edge as the state.
    m1_nx    = RED;
    m2_nx    = RED;
    mt_nx    = RED;
    s_nx     = RED;
    walk_nx  = 1'b0;
    grant_nx = 2'(phase_nx);
    col      = (state_nx == SRV_GREEN) ? GREEN : YELLOW;
    case (state_nx)
      MAIN_GREEN: begin
        m1_nx = GREEN;
        m2_nx = GREEN;
      end
      MAIN_YELLOW: begin
        m1_nx = YELLOW;
        m2_nx = YELLOW;
      end
      SRV_GREEN, SRV_YELLOW: begin
        case (phase_nx)
          PH_TURN: begin
            m1_nx = col;
            mt_nx = col;
          end
          PH_SIDE: s_nx = col;
          PH_PED:  walk_nx = (state_nx == SRV_GREEN);
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= RST_RED;
      phase   <= PH_MAIN;
      rr_ptr  <= PH_TURN;
      pending <= 3'b000;
      abort   <= 1'b0;
      m1_q    <= RED;
      m2_q    <= RED;
      mt_q    <= RED;
      s_q     <= RED;
      walk_q  <= 1'b0;
      grant_q <= 2'd0;
    end else begin
      state   <= state_nx;
      phase   <= phase_nx;
      rr_ptr  <= rr_nx;
      pending <= pending_nx;
      abort   <= abort_nx;
      m1_q    <= m1_nx;
      m2_q    <= m2_nx;
      mt_q    <= mt_nx;
      s_q     <= s_nx;
      walk_q  <= walk_nx;
      grant_q <= grant_nx;
    end
  end

  assign bus.light_M1 = m1_q;
  assign bus.light_M2 = m2_q;
  assign bus.light_MT = mt_q;
  assign bus.light_S  = s_q;
  assign bus.walk     = walk_q;
  assign bus.grant    = grant_q;
  assign bus.pending  = pending;

endmodule
